// File: rtl/pwm_regs_pkg.sv
// Shared constants for the PWM register block: ctrl bit map, default
// register offsets, reset value and the decoded register select type.
package pwm_regs_pkg;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_CNTRST = 2;
    localparam int CTRL_IRQEN  = 3;
    localparam int CTRL_OUTEN  = 4;
    localparam int CTRL_IRQF   = 5;
    localparam int CTRL_UPD    = 6;

    localparam int unsigned CTRL_OFS = 0;
    localparam int unsigned DIV_OFS  = 2;
    localparam int unsigned PER_OFS  = 4;
    localparam int unsigned DC_OFS   = 6;

    localparam logic [15:0] REG_RST_VAL = 16'h0000;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CTRL,
        SEL_DIV,
        SEL_PER,
        SEL_DC
    } reg_sel_e;

endpackage

// File: rtl/pwm_reg_file_if.sv
// Register-bus strobes between the Wishbone slave front end and the
// PWM register file.
interface pwm_reg_file_if;

    logic [15:0] reg_adr;
    logic [15:0] reg_data;
    logic        reg_we;
    logic        reg_re;
    logic [15:0] reg_rdata;

    modport master (
        output reg_adr,
        output reg_data,
        output reg_we,
        output reg_re,
        input  reg_rdata
    );

    modport slave (
        input  reg_adr,
        input  reg_data,
        input  reg_we,
        input  reg_re,
        output reg_rdata
    );

endinterface

// File: rtl/pwm_shadow_reg.sv
// 16-bit pending/active register pair: bus writes land in pending, and
// commit copies the pre-write pending value into active.
module pwm_shadow_reg
    import pwm_regs_pkg::*;
(
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic        i_load,
    input  logic [15:0] i_load_data,
    input  logic        i_commit,
    output logic [15:0] o_pending,
    output logic [15:0] o_active
);

    logic [15:0] pending_q, pending_d;
    logic [15:0] active_q, active_d;

    always_comb begin
        pending_d = i_load   ? i_load_data : pending_q;
        active_d  = i_commit ? pending_q   : active_q;
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            pending_q <= REG_RST_VAL;
            active_q  <= REG_RST_VAL;
        end else begin
            pending_q <= pending_d;
            active_q  <= active_d;
        end
    end

    assign o_pending = pending_q;
    assign o_active  = active_q;

endmodule

// File: rtl/pwm_reg_file.sv
// PWM register file: decodes register-bus strobes, holds ctrl plus three
// shadowed settings, and commits them to the core only at period boundaries.
module pwm_reg_file
    import pwm_regs_pkg::*;
#(
    parameter logic [15:0] base_adr        = 16'h0000,
    parameter int unsigned ctrl_spacing    = CTRL_OFS,
    parameter int unsigned divisor_spacing = DIV_OFS,
    parameter int unsigned period_spacing  = PER_OFS,
    parameter int unsigned DC_spacing      = DC_OFS
)
(
    input  logic                 i_wb_clk,
    input  logic                 i_wb_rst,
    pwm_reg_file_if.slave        bus,
    input  logic                 i_period_end,
    output logic                 o_ctrl_en,
    output logic                 o_ctrl_mode,
    output logic                 o_out_en,
    output logic                 o_cnt_rst,
    output logic [15:0]          o_divisor,
    output logic [15:0]          o_period,
    output logic [15:0]          o_dc,
    output logic                 o_irq
);

    localparam logic [15:0] CTRL_ADR = base_adr + 16'(ctrl_spacing);
    localparam logic [15:0] DIV_ADR  = base_adr + 16'(divisor_spacing);
    localparam logic [15:0] PER_ADR  = base_adr + 16'(period_spacing);
    localparam logic [15:0] DC_ADR   = base_adr + 16'(DC_spacing);

    reg_sel_e    sel;
    logic        wr_ctrl, wr_div, wr_per, wr_dc, cnt_wr, commit;
    logic [15:0] ctrl_rd;
    logic [15:0] div_pend, per_pend, dc_pend;
    logic [15:0] div_act, per_act, dc_act;

    logic        en_q, en_d;
    logic        mode_q, mode_d;
    logic        irqen_q, irqen_d;
    logic        outen_q, outen_d;
    logic        irqf_q, irqf_d;
    logic        upd_q, upd_d;
    logic        cnt_rst_q, cnt_rst_d;
    logic        armed_q, armed_d;
    logic [15:0] rdata_q, rdata_d;

    always_comb begin
        sel = SEL_NONE;
        if (bus.reg_adr == CTRL_ADR)     sel = SEL_CTRL;
        else if (bus.reg_adr == DIV_ADR) sel = SEL_DIV;
        else if (bus.reg_adr == PER_ADR) sel = SEL_PER;
        else if (bus.reg_adr == DC_ADR)  sel = SEL_DC;
    end

    assign wr_ctrl = bus.reg_we && (sel == SEL_CTRL);
    assign wr_div  = bus.reg_we && (sel == SEL_DIV);
    assign wr_per  = bus.reg_we && (sel == SEL_PER);
    assign wr_dc   = bus.reg_we && (sel == SEL_DC);
    assign cnt_wr  = wr_ctrl && bus.reg_data[CTRL_CNTRST];
    assign commit  = upd_q && (i_period_end || !en_q);

    always_comb begin
        ctrl_rd             = REG_RST_VAL;
        ctrl_rd[CTRL_EN]    = en_q;
        ctrl_rd[CTRL_MODE]  = mode_q;
        ctrl_rd[CTRL_IRQEN] = irqen_q;
        ctrl_rd[CTRL_OUTEN] = outen_q;
        ctrl_rd[CTRL_IRQF]  = irqf_q;
        ctrl_rd[CTRL_UPD]   = upd_q;
    end

    // Flag set beats a coincident W1C, and a new pending write beats the
    // commit's clear of upd so the freshly written value is not lost.
    always_comb begin
        en_d    = en_q;
        mode_d  = mode_q;
        irqen_d = irqen_q;
        outen_d = outen_q;
        if (wr_ctrl) begin
            en_d    = bus.reg_data[CTRL_EN];
            mode_d  = bus.reg_data[CTRL_MODE];
            irqen_d = bus.reg_data[CTRL_IRQEN];
            outen_d = bus.reg_data[CTRL_OUTEN];
        end

        irqf_d = irqf_q;
        if (wr_ctrl && bus.reg_data[CTRL_IRQF]) irqf_d = 1'b0;
        if (i_period_end && irqen_q)           irqf_d = 1'b1;

        upd_d = upd_q;
        if (commit)                     upd_d = 1'b0;
        if (wr_div || wr_per || wr_dc) upd_d = 1'b1;

        cnt_rst_d = cnt_wr && armed_q;
        armed_d   = !cnt_wr;

        rdata_d = rdata_q;
        if (bus.reg_re) begin
            case (sel)
                SEL_CTRL: rdata_d = ctrl_rd;
                SEL_DIV:  rdata_d = div_pend;
                SEL_PER:  rdata_d = per_pend;
                SEL_DC:   rdata_d = dc_pend;
                default:  rdata_d = REG_RST_VAL;
            endcase
        end
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            en_q      <= 1'b0;
            mode_q    <= 1'b0;
            irqen_q   <= 1'b0;
            outen_q   <= 1'b0;
            irqf_q    <= 1'b0;
            upd_q     <= 1'b0;
            cnt_rst_q <= 1'b0;
            armed_q   <= 1'b1;
            rdata_q   <= REG_RST_VAL;
        end else begin
            en_q      <= en_d;
            mode_q    <= mode_d;
            irqen_q   <= irqen_d;
            outen_q   <= outen_d;
            irqf_q    <= irqf_d;
            upd_q     <= upd_d;
            cnt_rst_q <= cnt_rst_d;
            armed_q   <= armed_d;
            rdata_q   <= rdata_d;
        end
    end

    pwm_shadow_reg u_div_shadow (
        .i_wb_clk    (i_wb_clk),
        .i_wb_rst    (i_wb_rst),
        .i_load      (wr_div),
        .i_load_data (bus.reg_data),
        .i_commit    (commit),
        .o_pending   (div_pend),
        .o_active    (div_act)
    );

    pwm_shadow_reg u_per_shadow (
        .i_wb_clk    (i_wb_clk),
        .i_wb_rst    (i_wb_rst),
        .i_load      (wr_per),
        .i_load_data (bus.reg_data),
        .i_commit    (commit),
        .o_pending   (per_pend),
        .o_active    (per_act)
    );

    pwm_shadow_reg u_dc_shadow (
        .i_wb_clk    (i_wb_clk),
        .i_wb_rst    (i_wb_rst),
        .i_load      (wr_dc),
        .i_load_data (bus.reg_data),
        .i_commit    (commit),
        .o_pending   (dc_pend),
        .o_active    (dc_act)
    );

    // Period and DC always commit together, so clamping the active pair
    // gives the same result as clamping the pending pair at commit time.
    assign o_dc = (dc_act < per_act) ? dc_act : per_act;

    assign bus.reg_rdata = rdata_q;
    assign o_ctrl_en     = en_q;
    assign o_ctrl_mode   = mode_q;
    assign o_out_en      = outen_q;
    assign o_cnt_rst     = cnt_rst_q;
    assign o_divisor     = div_act;
    assign o_period      = per_act;
    assign o_irq         = irqen_q && irqf_q;

endmodule

// File: tb/tb_pwm_reg_file.sv
// Directed bench for pwm_reg_file: reads are checked through an expected-value
// queue, outputs through immediate assertions after each clock edge.
module tb_pwm_reg_file;

    logic        i_wb_clk = 1'b0;
    logic        i_wb_rst = 1'b1;
    logic        i_period_end = 1'b0;
    logic        o_ctrl_en, o_ctrl_mode, o_out_en, o_cnt_rst, o_irq;
    logic [15:0] o_divisor, o_period, o_dc;

    pwm_reg_file_if bus ();

    pwm_reg_file dut (
        .i_wb_clk     (i_wb_clk),
        .i_wb_rst     (i_wb_rst),
        .bus          (bus),
        .i_period_end (i_period_end),
        .o_ctrl_en    (o_ctrl_en),
        .o_ctrl_mode  (o_ctrl_mode),
        .o_out_en     (o_out_en),
        .o_cnt_rst    (o_cnt_rst),
        .o_divisor    (o_divisor),
        .o_period     (o_period),
        .o_dc         (o_dc),
        .o_irq        (o_irq)
    );

    always #5 i_wb_clk = ~i_wb_clk;

    int          checks = 0;
    int          fails  = 0;
    logic [15:0] exp_q[$];
    string       tag_q[$];

    task automatic cycle();
        @(posedge i_wb_clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; a read pops its expected value once data is due.
    task automatic apply_stimulus(input logic we, input logic re, input logic [15:0] adr,
                                  input logic [15:0] data, input logic pe);
        string       tag;
        logic [15:0] exp;
        bus.reg_we   = we;
        bus.reg_re   = re;
        bus.reg_adr  = adr;
        bus.reg_data = data;
        i_period_end = pe;
        cycle();
        bus.reg_we   = 1'b0;
        bus.reg_re   = 1'b0;
        i_period_end = 1'b0;
        if (re) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL scoreboard: observed empty queue expected an entry");
            end else begin
                exp = exp_q.pop_front();
                tag = tag_q.pop_front();
                check_output(tag, bus.reg_rdata, exp);
            end
        end
    endtask

    task automatic write_reg(input logic [15:0] adr, input logic [15:0] data);
        apply_stimulus(1'b1, 1'b0, adr, data, 1'b0);
    endtask

    task automatic read_expect(input logic [15:0] adr, input logic [15:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        apply_stimulus(1'b0, 1'b1, adr, 16'h0000, 1'b0);
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    initial begin
        int   pulses;
        logic first;
        bus.reg_we   = 1'b0;
        bus.reg_re   = 1'b0;
        bus.reg_adr  = 16'h0000;
        bus.reg_data = 16'h0000;
        cycle();
        cycle();
        i_wb_rst = 1'b0;

        // Load some state, then reset asynchronously between edges
        write_reg(16'h0004, 16'd7);
        read_expect(16'h0004, 16'd7, "pre_rst_rd_period");
        check_output("pre_rst_period", o_period, 16'd7);
        write_reg(16'h0000, 16'h0013);
        check_output("pre_rst_en", 16'(o_ctrl_en), 16'd1);
        check_output("pre_rst_out_en", 16'(o_out_en), 16'd1);
        #3;
        i_wb_rst = 1'b1;
        #1;
        check_output("rst_en", 16'(o_ctrl_en), 16'd0);
        check_output("rst_mode", 16'(o_ctrl_mode), 16'd0);
        check_output("rst_out_en", 16'(o_out_en), 16'd0);
        check_output("rst_period", o_period, 16'd0);
        check_output("rst_dc", o_dc, 16'd0);
        check_output("rst_divisor", o_divisor, 16'd0);
        check_output("rst_rdata", bus.reg_rdata, 16'd0);
        check_output("rst_irq", 16'(o_irq), 16'd0);
        check_output("rst_cnt_rst", 16'(o_cnt_rst), 16'd0);
        cycle();
        i_wb_rst = 1'b0;
        read_expect(16'h0004, 16'd0, "post_rst_rd_period");
        read_expect(16'h0000, 16'h0000, "post_rst_rd_ctrl");

        // Disabled core commits immediately
        write_reg(16'h0002, 16'd5);
        write_reg(16'h0004, 16'd100);
        write_reg(16'h0006, 16'd40);
        idle();
        check_output("dis_period", o_period, 16'd100);
        check_output("dis_dc", o_dc, 16'd40);
        check_output("dis_divisor", o_divisor, 16'd5);
        read_expect(16'h0006, 16'd40, "dis_rd_dc");
        read_expect(16'h0000, 16'h0000, "dis_rd_ctrl");

        // Enabled core holds new period until the period boundary
        write_reg(16'h0000, 16'h0001);
        write_reg(16'h0004, 16'd200);
        idle();
        check_output("shd_period_held", o_period, 16'd100);
        read_expect(16'h0000, 16'h0041, "shd_rd_ctrl_upd");
        apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        check_output("shd_period_commit", o_period, 16'd200);
        check_output("shd_dc_commit", o_dc, 16'd40);
        read_expect(16'h0000, 16'h0001, "shd_rd_ctrl_clr");

        // Clamp, with a DC write landing on the commit edge
        write_reg(16'h0004, 16'd50);
        write_reg(16'h0006, 16'd80);
        apply_stimulus(1'b1, 1'b0, 16'h0006, 16'd30, 1'b1);
        check_output("clamp_period", o_period, 16'd50);
        check_output("clamp_dc", o_dc, 16'd50);
        read_expect(16'h0006, 16'd30, "clamp_rd_dc_pend");
        read_expect(16'h0000, 16'h0041, "clamp_rd_ctrl_upd");

        // Interrupt set, W1C clear, and set winning over a coincident clear
        write_reg(16'h0000, 16'h0009);
        check_output("irq_idle", 16'(o_irq), 16'd0);
        apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        check_output("irq_set", 16'(o_irq), 16'd1);
        check_output("irq_dc_commit", o_dc, 16'd30);
        read_expect(16'h0000, 16'h0029, "irq_rd_ctrl");
        write_reg(16'h0000, 16'h0029);
        check_output("irq_w1c", 16'(o_irq), 16'd0);
        apply_stimulus(1'b1, 1'b0, 16'h0000, 16'h0029, 1'b1);
        check_output("irq_set_wins", 16'(o_irq), 16'd1);

        // Unmatched address write changes nothing
        write_reg(16'h0008, 16'hFFFF);
        check_output("dec_period", o_period, 16'd50);
        check_output("dec_dc", o_dc, 16'd30);
        check_output("dec_divisor", o_divisor, 16'd5);
        check_output("dec_en", 16'(o_ctrl_en), 16'd1);
        check_output("dec_mode", 16'(o_ctrl_mode), 16'd0);
        check_output("dec_out_en", 16'(o_out_en), 16'd0);
        check_output("dec_irq", 16'(o_irq), 16'd1);
        read_expect(16'h0004, 16'd50, "dec_rd_period");
        read_expect(16'h0000, 16'h0029, "dec_rd_ctrl");

        // Held cnt_rst write yields one pulse, on the first following cycle
        pulses = 0;
        first  = 1'b0;
        bus.reg_we   = 1'b1;
        bus.reg_adr  = 16'h0000;
        bus.reg_data = 16'h000D;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (i == 0) first = o_cnt_rst;
            if (o_cnt_rst) pulses++;
        end
        bus.reg_we = 1'b0;
        cycle();
        if (o_cnt_rst) pulses++;
        check_output("cnt_rst_first", 16'(first), 16'd1);
        check_output("cnt_rst_pulses", 16'(pulses), 16'd1);
        read_expect(16'h0003, 16'h0000, "dec_rd_unmapped");
        read_expect(16'h0000, 16'h0029, "cnt_rd_ctrl");

        // Simultaneous write and read returns the pre-write value
        exp_q.push_back(16'd50);
        tag_q.push_back("wr_rd_pre_value");
        apply_stimulus(1'b1, 1'b1, 16'h0004, 16'd77, 1'b0);
        read_expect(16'h0004, 16'd77, "wr_rd_new_value");
        idle();
        check_output("rdata_hold", bus.reg_rdata, 16'd77);
        check_output("wr_rd_period_held", o_period, 16'd50);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
